// File: rtl/rom_fetch_responder.sv
// Program memory that answers the CPU's 8-cycle nibble-multiplexed instruction fetch.
// The address is captured in cycles 0-2. The selected byte is returned opcode nibble first
// in cycles 3 and 4. A nibble-serial port loads the memory while the block is off the bus.
module rom_fetch_responder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [3:0]  CHIP_ID    = 4'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [2:0]            cycle,
  input  logic [3:0]            bus_in,
  output logic [3:0]            bus_out,
  output logic                  bus_out_enable,
  input  logic                  prog_mode,
  input  logic                  prog_valid,
  input  logic [3:0]            prog_nibble,
  output logic                  prog_wrapped
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic {
    PhaseHi = 1'b0,
    PhaseLo = 1'b1
  } phase_e;

  logic [7:0]            mem_q [Depth];
  logic [3:0]            addr_lo_q, addr_lo_d;
  logic [3:0]            addr_hi_q, addr_hi_d;
  logic                  selected_q, selected_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  phase_e                phase_q, phase_d;
  logic                  prog_prev_q;
  logic                  wrapped_q, wrapped_d;

  logic [7:0]            addr_full;
  logic [7:0]            addr_upper;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic [7:0]            rd_word;

  logic                  prog_rise;
  logic [DEPTH_LOG2-1:0] eff_ptr;
  phase_e                eff_phase;
  logic [7:0]            wr_old;
  logic                  mem_we;
  logic [7:0]            mem_wdata;

  // Address decode; shifting by DEPTH_LOG2=8 leaves zero, so every address is in range.
  assign addr_full  = {addr_hi_q, addr_lo_q};
  assign addr_upper = addr_full >> DEPTH_LOG2;
  assign in_range   = (addr_upper == 8'h00);
  assign addr_idx   = addr_full[DEPTH_LOG2-1:0];
  assign rd_word    = mem_q[addr_idx];

  // A fresh entry into programming mode restarts the write stream at byte 0, high nibble,
  // and applies before a nibble presented in the same cycle.
  assign prog_rise = prog_mode & ~prog_prev_q;
  assign eff_ptr   = prog_rise ? '0 : ptr_q;
  assign eff_phase = prog_rise ? PhaseHi : phase_q;
  assign wr_old    = mem_q[eff_ptr];

  // Next-state logic for the fetch capture and the programming write stream.
  always_comb begin
    addr_lo_d  = addr_lo_q;
    addr_hi_d  = addr_hi_q;
    selected_d = selected_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    wrapped_d  = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = wr_old;

    if (prog_mode) begin
      selected_d = 1'b0;
      ptr_d      = eff_ptr;
      phase_d    = eff_phase;
      if (prog_valid) begin
        mem_we = 1'b1;
        if (eff_phase == PhaseHi) begin
          mem_wdata = {prog_nibble, wr_old[3:0]};
          phase_d   = PhaseLo;
        end else begin
          mem_wdata = {wr_old[7:4], prog_nibble};
          phase_d   = PhaseHi;
          ptr_d     = eff_ptr + DEPTH_LOG2'(1);
          wrapped_d = (eff_ptr == '1);
        end
      end
    end else begin
      case (cycle)
        3'd0:    addr_lo_d  = bus_in;
        3'd1:    addr_hi_d  = bus_in;
        3'd2:    selected_d = (bus_in == CHIP_ID) && in_range;
        default: ;
      endcase
    end
  end

  // State and memory update; halt freezes everything, reset overrides all.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
      addr_lo_q   <= 4'h0;
      addr_hi_q   <= 4'h0;
      selected_q  <= 1'b0;
      ptr_q       <= '0;
      phase_q     <= PhaseHi;
      prog_prev_q <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (!halt) begin
      addr_lo_q   <= addr_lo_d;
      addr_hi_q   <= addr_hi_d;
      selected_q  <= selected_d;
      ptr_q       <= ptr_d;
      phase_q     <= phase_d;
      prog_prev_q <= prog_mode;
      wrapped_q   <= wrapped_d;
      if (mem_we) begin
        mem_q[eff_ptr] <= mem_wdata;
      end
    end
  end

  // Bus drive is combinational so data appears in the same clock as cycle 3/4.
  always_comb begin
    bus_out        = 4'h0;
    bus_out_enable = 1'b0;
    if (!reset && !halt && !prog_mode && selected_q) begin
      if (cycle == 3'd3) begin
        bus_out        = rd_word[7:4];
        bus_out_enable = 1'b1;
      end else if (cycle == 3'd4) begin
        bus_out        = rd_word[3:0];
        bus_out_enable = 1'b1;
      end
    end
  end

  assign prog_wrapped = wrapped_q & ~halt & ~reset;

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Scoreboard bench for rom_fetch_responder: stimulus pushes expected driven nibbles,
// and a negedge monitor pops one whenever the block enables the bus.
module tb_rom_fetch_responder;

  localparam int unsigned DL   = 4;
  localparam logic [3:0]  Chip = 4'h5;

  logic       clock;
  logic       reset;
  logic       halt;
  logic [2:0] cycle;
  logic [3:0] bus_in;
  logic [3:0] bus_out;
  logic       bus_out_enable;
  logic       prog_mode;
  logic       prog_valid;
  logic [3:0] prog_nibble;
  logic       prog_wrapped;

  rom_fetch_responder #(
    .DEPTH_LOG2 (DL),
    .CHIP_ID    (Chip)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .halt           (halt),
    .cycle          (cycle),
    .bus_in         (bus_in),
    .bus_out        (bus_out),
    .bus_out_enable (bus_out_enable),
    .prog_mode      (prog_mode),
    .prog_valid     (prog_valid),
    .prog_nibble    (prog_nibble),
    .prog_wrapped   (prog_wrapped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [3:0] nib;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   wrap_cnt = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(string tag, logic [3:0] nib);
    exp_t e;
    e.tag = tag;
    e.nib = nib;
    exp_q.push_back(e);
  endtask

  // Every expected drive of a scenario must have been consumed by the monitor.
  task automatic drain(string tag);
    check({tag, "_pending_drives"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fetch(string tag, logic [7:0] addr, logic [3:0] chip, bit sel,
                       logic [7:0] data);
    for (int c = 0; c < 8; c++) begin
      cycle  = c[2:0];
      bus_in = (c == 0) ? addr[3:0] : (c == 1) ? addr[7:4] : (c == 2) ? chip : 4'h0;
      if (sel && c == 3) push({tag, "_hi"}, data[7:4]);
      if (sel && c == 4) push({tag, "_lo"}, data[3:0]);
      step();
    end
  endtask

  task automatic prog_write(logic [3:0] nib);
    prog_mode   = 1'b1;
    prog_valid  = 1'b1;
    prog_nibble = nib;
    step();
    prog_valid  = 1'b0;
  endtask

  // Monitor: each enabled cycle consumes one expected nibble; idle cycles must show zero.
  always @(negedge clock) begin
    if (prog_wrapped === 1'b1) wrap_cnt++;
    if (bus_out_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_drive: enable=1 bus_out=%h, want enable=0", bus_out);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, bus_out, mon_e.nib);
      end
    end else begin
      check("idle_bus_out", bus_out, 0);
    end
  end

  initial begin
    reset = 1'b1; halt = 1'b0; cycle = 3'd0; bus_in = 4'h0;
    prog_mode = 1'b0; prog_valid = 1'b0; prog_nibble = 4'h0;
    step();
    step();
    check("rst_enable", bus_out_enable, 0);
    check("rst_bus_out", bus_out, 0);
    check("rst_wrapped", prog_wrapped, 0);
    reset = 1'b0;
    step();

    // Load A5 at 0 and 3C at 1, first nibble on the entry edge.
    prog_write(4'hA);
    prog_write(4'h5);
    prog_write(4'h3);
    prog_write(4'hC);
    prog_mode = 1'b0;
    step();
    fetch("t1_a1", 8'h01, Chip, 1'b1, 8'h3C);
    fetch("t1_a0", 8'h00, Chip, 1'b1, 8'hA5);
    drain("t1");

    fetch("t2_chip_miss", 8'h00, 4'h4, 1'b0, 8'h00);
    drain("t2");
    fetch("t3_out_of_range", 8'h12, Chip, 1'b0, 8'h00);
    drain("t3");

    // 32 nibbles fill all 16 bytes and wrap the pointer exactly once.
    for (int i = 0; i < 32; i++) begin
      prog_write(i[3:0]);
      if (i == 30) check("wrap_early", prog_wrapped, 0);
    end
    check("wrap_pulse", prog_wrapped, 1);
    step();
    check("wrap_pulse_end", prog_wrapped, 0);
    step();
    check("wrap_count", wrap_cnt, 1);
    prog_write(4'hF);
    prog_mode = 1'b0;
    step();
    fetch("t4_a0", 8'h00, Chip, 1'b1, 8'hF1);
    fetch("t4_a9", 8'h09, Chip, 1'b1, 8'h23);
    fetch("t4_af", 8'h0F, Chip, 1'b1, 8'hEF);
    drain("t4");

    // Halt in cycle 3 with garbage on the bus; captured address and select must survive.
    cycle = 3'd0; bus_in = 4'h9; step();
    cycle = 3'd1; bus_in = 4'h0; step();
    cycle = 3'd2; bus_in = Chip; step();
    cycle = 3'd3; bus_in = 4'h0; halt = 1'b1;
    check("halt_enable", bus_out_enable, 0);
    check("halt_bus_out", bus_out, 0);
    step();
    cycle = 3'd0; bus_in = 4'hF; step();
    halt = 1'b0; cycle = 3'd3; bus_in = 4'h0;
    push("t5_hi", 4'h2);
    step();
    cycle = 3'd4; push("t5_lo", 4'h3); step();
    for (int c = 5; c < 8; c++) begin
      cycle = c[2:0];
      step();
    end
    drain("t5");

    // Entering programming mode mid-instruction drops the pending drive.
    cycle = 3'd0; bus_in = 4'h0; step();
    cycle = 3'd1; step();
    cycle = 3'd2; bus_in = Chip; step();
    cycle = 3'd3; bus_in = 4'h0; prog_mode = 1'b1; step();
    cycle = 3'd4; prog_mode = 1'b0; step();
    for (int c = 5; c < 8; c++) begin
      cycle = c[2:0];
      step();
    end
    drain("t6");

    // Reset mid-fetch clears the memory.
    cycle = 3'd0; bus_in = 4'h1; step();
    cycle = 3'd1; bus_in = 4'h0; reset = 1'b1;
    check("midrst_enable", bus_out_enable, 0);
    check("midrst_bus_out", bus_out, 0);
    check("midrst_wrapped", prog_wrapped, 0);
    step();
    reset = 1'b0;
    fetch("t7_a1", 8'h01, Chip, 1'b1, 8'h00);
    fetch("t7_af", 8'h0F, Chip, 1'b1, 8'h00);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_responder.md
Name: rom_fetch_responder

Overview:
- Bus-side program memory that answers the CPU's 8-cycle multiplexed 4-bit instruction fetch.
- Captures the address nibbles the PC stack places on the bus in cycles 0-2.
- If the address decodes to this chip, returns the stored instruction byte, opcode nibble first, in cycles 3 and 4.
- A nibble-serial programming port loads the memory from outside while the responder is taken off the bus.

Parameters:
- DEPTH_LOG2, 4, log2 of memory depth in bytes; legal range 1..8.
- CHIP_ID, 4'h0, value the cycle-2 bus nibble must equal for this chip to respond.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- halt  input  1  freezes all state; bus output disabled while high.
- cycle  input  3  CPU bus phase, 0..7, supplied by the core.
- bus_in  input  4  nibble currently on the shared bus.
- bus_out  output  4  nibble driven by this block.
- bus_out_enable  output  1  high when bus_out is to be placed on the bus.
- prog_mode  input  1  high = programming mode; responder is off the bus.
- prog_valid  input  1  one nibble on prog_nibble is written this cycle.
- prog_nibble  input  4  programming data.
- prog_wrapped  output  1  one-cycle pulse when the write pointer wraps from DEPTH-1 to 0.

Behaviour:
- Reset:
  - Memory clears to 0; addr_lo, addr_hi, selected and write pointer clear to 0; write phase is HI.
  - bus_out=0, bus_out_enable=0, prog_wrapped=0.
  - Reset takes priority over halt, prog_mode and every other input.
- halt high (not in reset):
  - No register updates and no memory writes.
  - bus_out_enable=0, bus_out=0; prog_wrapped=0.
- Fetch path (prog_mode low, halt low):
  - cycle 0: addr_lo <= bus_in.
  - cycle 1: addr_hi <= bus_in.
  - cycle 2: selected <= (bus_in == CHIP_ID) and ({addr_hi,addr_lo}[7:DEPTH_LOG2] == 0). Upper bits are ignored when DEPTH_LOG2=8.
  - cycle 3: if selected, bus_out=mem[addr][7:4] and bus_out_enable=1.
  - cycle 4: if selected, bus_out=mem[addr][3:0] and bus_out_enable=1.
  - cycles 5-7: selected holds its value; it is not consulted.
  - Outputs are combinational from cycle, selected and the addressed memory word, so data is valid in the same clock as cycle==3/4. No extra latency.
  - Outside driving cycles, bus_out=0 and bus_out_enable=0.
  - The address used is {addr_hi,addr_lo}[DEPTH_LOG2-1:0].
- Programming path:
  - prog_mode low->high edge (registered previous value): pointer <= 0, phase <= HI, selected <= 0.
  - While prog_mode high:
    - selected forced 0; bus_out_enable=0; the address registers do not update.
  - prog_valid high, phase HI: mem[ptr][7:4] <= prog_nibble; phase <= LO.
  - prog_valid high, phase LO: mem[ptr][3:0] <= prog_nibble; phase <= HI; ptr <= ptr+1 mod DEPTH.
    - When ptr was DEPTH-1, prog_wrapped pulses high for the next cycle.
  - prog_valid on the same cycle as the rising edge of prog_mode: the edge reset applies first, and the nibble is written to mem[0][7:4].
  - prog_valid with prog_mode low is ignored.
- prog_mode high->low:
  - Phase and pointer keep their values but are reset on the next entry.
  - A half-written byte keeps its new high nibble.
  - Fetch resumes at the next cycle 0.
- Mid-instruction entry into programming mode: selected clears at once, and cycles 3/4 of that instruction are not driven.
- Reset mid-fetch or mid-programming: everything returns to reset values on the next edge, with memory zeroed.
- Unselected chip (CHIP_ID mismatch or out-of-range address): never drives the bus in that instruction.

Test Plan:
- Load 0xA5 at address 0 and 0x3C at address 1 with prog_mode=1 and four prog_valid nibbles (A,5,3,C). Exit, then fetch with bus_in 1,0,CHIP_ID in cycles 0-2 -> cycle 3 drives 3 with enable=1, cycle 4 drives C, cycles 5-7 enable=0.
- Fetch address 0 with cycle-2 nibble != CHIP_ID -> bus_out_enable stays 0 for all 8 cycles.
- DEPTH_LOG2=4, fetch address 0x12 with a matching chip nibble -> not selected, enable=0 in cycles 3/4.
- Write 2*DEPTH nibbles (32 at default) -> prog_wrapped pulses exactly once, one cycle after the last nibble. A 33rd nibble overwrites mem[0][7:4].
- Assert halt during cycle 3 of a selected fetch -> enable=0 while halted, and addr/selected unchanged. Deassert halt, cycle 4 -> correct low nibble driven.
- Assert reset during cycle 1 of a fetch following a load -> all outputs 0. A subsequent fetch of any address returns 0,0 with enable=1 if selected.
